bit_serial_adder: RTL

- Sequential wrapper that drives one instance of the team's `structuralFullAdder` and consumes its output.
- Adds two WIDTH-bit operands LSB-first, one bit per clock, through that single 1-bit slice.
- Keeps the ripple carry in a flip-flop and shifts sum bits into a result register.
- Upstream: operand/start producer. Downstream: any consumer of sum/carryout/overflow qualified by done.

---
 rtl/bit_serial_adder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: pushes two WIDTH-bit operands LSB-first through one full-adder
// slice, with the ripple carry held in a flop and sum bits assembled in a shift register.
`timescale 1ns/1ps

module structuralFullAdder (
    input  logic a,
    input  logic b,
    input  logic carryin,
    output logic sum,
    output logic carryout
);
    logic ab_xor;
    logic ab_and;
    logic cx_and;

    assign ab_xor   = a ^ b;
    assign ab_and   = a & b;
    assign cx_and   = ab_xor & carryin;
    assign sum      = ab_xor ^ carryin;
    assign carryout = ab_and | cx_and;
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             carry_reg;
    logic [CW-1:0]    count_reg;

    logic             slice_sum;
    logic             slice_carry;
    logic [WIDTH-1:0] acc_next;

    structuralFullAdder u_slice (
        .a        (a_reg[0]),
        .b        (b_reg[0]),
        .carryin  (carry_reg),
        .sum      (slice_sum),
        .carryout (slice_carry)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign acc_next = {slice_sum, acc_reg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            count_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= carryin;
                        acc_reg   <= '0;
                        count_reg <= '0;
                        busy      <= 1'b1;
                        state_reg <= SHIFT;
                    end else begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                SHIFT: begin
                    acc_reg   <= acc_next;
                    a_reg     <= {1'b0, a_reg[WIDTH-1:1]};
                    b_reg     <= {1'b0, b_reg[WIDTH-1:1]};
                    carry_reg <= slice_carry;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == CW'(WIDTH - 1)) begin
                        // carry_reg here is the carry into the MSB slice.
                        sum       <= acc_next;
                        carryout  <= slice_carry;
                        overflow  <= carry_reg ^ slice_carry;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule
